// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier / accumulator datapath.
// Holds the product width default, a clog2 helper and the accumulator FSM states.
package mul_pkg;

    localparam int DIN_W = 9;

    // Bits needed to count 0..v-1. Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } acc_state_e;

endpackage

// File: rtl/mul_acc_fifo.sv
// Synchronous FIFO buffering completed frame sums.
// Ports: clk/rst, i_push/i_data write side, i_pop read side, o_full/o_empty flags,
// o_head = oldest entry (0 while empty). A push while full is accepted only with a same-cycle pop.
module mul_acc_fifo
    import mul_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra MSB distinguishes full from empty when the indices match.
    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW])
                  && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

    assign w_do_pop  = i_pop && !o_empty;
    // When full, the popped slot is the one being written; head was read before the edge.
    assign w_do_push = i_push && (!o_full || w_do_pop);

    assign o_head = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr[AW-1:0]] <= i_data;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_acc.sv
// Frame accumulator: sums every FRAME_LEN products into one frame sum and queues it.
// Ports: din/din_en product stream (never stalled), frame_clr drops the partial frame,
// acc_out/acc_vld/acc_rdy sum handshake, beat_cnt/busy frame progress, ovf sticky drop flag.
module mul_acc
    import mul_pkg::*;
#(
    parameter int DIN_W      = mul_pkg::DIN_W,
    parameter int FRAME_LEN  = 4,
    parameter int ACC_W      = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din_en,
    input  logic [DIN_W-1:0]              din,
    input  logic                          frame_clr,
    output logic [ACC_W-1:0]              acc_out,
    output logic                          acc_vld,
    input  logic                          acc_rdy,
    output logic [clog2(FRAME_LEN)-1:0]   beat_cnt,
    output logic                          ovf,
    output logic                          busy
);

    localparam int CNT_W = clog2(FRAME_LEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);
    localparam longint MAX_SUM = longint'(FRAME_LEN) * ((longint'(1) << DIN_W) - 1);

    // A full frame of maximum products must fit without wrapping.
    if (MAX_SUM >= (longint'(1) << ACC_W)) begin : g_bad_acc_w
        $error("mul_acc: ACC_W too narrow for FRAME_LEN * max product");
    end

    acc_state_e       r_state;
    acc_state_e       w_nxt_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_nxt_acc;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [ACC_W-1:0] w_din_ext;
    logic [ACC_W-1:0] w_sum;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_drop;
    logic             r_ovf;

    assign w_din_ext = ACC_W'(din);
    assign w_sum     = r_acc + w_din_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_acc   <= w_nxt_acc;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_acc   = r_acc;
        w_nxt_cnt   = r_cnt;
        w_push      = 1'b0;
        if (din_en && frame_clr) begin
            // The clearing beat opens the next frame.
            w_nxt_acc   = w_din_ext;
            w_nxt_cnt   = CNT_W'(1);
            w_nxt_state = ST_ACC;
        end else if (din_en) begin
            unique case (r_state)
                ST_IDLE: begin
                    w_nxt_acc   = w_din_ext;
                    w_nxt_cnt   = CNT_W'(1);
                    w_nxt_state = ST_ACC;
                end
                ST_ACC: begin
                    if (r_cnt == LAST) begin
                        w_push      = 1'b1;
                        w_nxt_acc   = '0;
                        w_nxt_cnt   = '0;
                        w_nxt_state = ST_IDLE;
                    end else begin
                        w_nxt_acc = w_sum;
                        w_nxt_cnt = r_cnt + 1'b1;
                    end
                end
            endcase
        end else if (frame_clr) begin
            w_nxt_acc   = '0;
            w_nxt_cnt   = '0;
            w_nxt_state = ST_IDLE;
        end
    end

    assign w_pop  = acc_rdy && !w_empty;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end
    end

    mul_acc_fifo #(
        .WIDTH (ACC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_sum),
        .i_pop   (acc_rdy),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (acc_out)
    );

    assign acc_vld  = !w_empty;
    assign beat_cnt = r_cnt;
    assign busy     = (r_state == ST_ACC);
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_mul_acc.sv
// Self-checking bench for mul_acc: directed frames plus randomized traffic
// against a queue-based frame-sum model.
module tb_mul_acc;

    localparam int FL    = 4;
    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        din_en;
    logic [8:0]  din;
    logic        frame_clr;
    logic [11:0] acc_out;
    logic        acc_vld;
    logic        acc_rdy;
    logic [1:0]  beat_cnt;
    logic        ovf;
    logic        busy;

    mul_acc dut (
        .clk       (clk),
        .rst       (rst),
        .din_en    (din_en),
        .din       (din),
        .frame_clr (frame_clr),
        .acc_out   (acc_out),
        .acc_vld   (acc_vld),
        .acc_rdy   (acc_rdy),
        .beat_cnt  (beat_cnt),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    int m_acc;
    int m_cnt;
    int m_q[$];
    bit m_ovf;
    int got[$];

    int prod[12] = '{15, 28, 39, 48, 55, 60, 63, 64, 63, 60, 55, 48};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Frame-level reference: partial sum, beat count, queue of finished sums.
    task automatic model_step(input bit en, input int d, input bit clr, input bit rdy, input bit rs);
        bit pop;
        bit push;
        int sum;
        if (rs) begin
            m_acc = 0;
            m_cnt = 0;
            m_q.delete();
            m_ovf = 0;
            return;
        end
        pop  = (m_q.size() != 0) && rdy;
        push = 0;
        sum  = 0;
        if (en && clr) begin
            m_acc = d;
            m_cnt = 1;
        end else if (en) begin
            if (m_cnt == FL - 1) begin
                sum   = m_acc + d;
                push  = 1;
                m_acc = 0;
                m_cnt = 0;
            end else begin
                m_acc += d;
                m_cnt++;
            end
        end else if (clr) begin
            m_acc = 0;
            m_cnt = 0;
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(sum);
            else m_ovf = 1;
        end
    endtask

    task automatic compare();
        chk("acc_vld", 32'(acc_vld), 32'(m_q.size() != 0));
        chk("acc_out", 32'(acc_out), (m_q.size() != 0) ? m_q[0] : 0);
        chk("beat_cnt", 32'(beat_cnt), m_cnt);
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
    endtask

    task automatic cyc(input bit en, input int d, input bit clr, input bit rdy, input bit rs);
        int dd;
        dd        = d;
        din_en    = en;
        din       = dd[8:0];
        frame_clr = clr;
        acc_rdy   = rdy;
        rst       = rs;
        if (!rs && acc_vld === 1'b1 && rdy) got.push_back(int'(acc_out));
        @(posedge clk);
        model_step(en, d, clr, rdy, rs);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        got.delete();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, rdy, 0);
    endtask

    task automatic chk_got(input string nm, input int n, input int a, input int b, input int c);
        int e[3];
        e[0] = a;
        e[1] = b;
        e[2] = c;
        chk({nm, "_count"}, got.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < got.size()) chk($sformatf("%s_%0d", nm, i), got[i], e[i]);
        end
        got.delete();
    endtask

    initial begin
        din_en    = 0;
        din       = '0;
        frame_clr = 0;
        acc_rdy   = 0;
        rst       = 1;
        m_acc     = 0;
        m_cnt     = 0;
        m_ovf     = 0;
        @(negedge clk);

        do_reset();
        chk("reset_vld", 32'(acc_vld), 0);
        chk("reset_out", 32'(acc_out), 0);

        // Back-to-back frames.
        for (int i = 0; i < 12; i++) cyc(1, prod[i], 0, 1, 0);
        idle(3, 1);
        chk_got("basic", 3, 130, 242, 226);
        chk("basic_ovf", 32'(ovf), 0);

        // Gapped input.
        for (int i = 0; i < 12; i++) begin
            cyc(1, prod[i], 0, 1, 0);
            cyc(0, 511, 0, 1, 0);
            if (i == 0) chk("gap_hold", 32'(beat_cnt), 1);
        end
        idle(2, 1);
        chk_got("gapped", 3, 130, 242, 226);

        // Overrun: third sum dropped.
        for (int i = 0; i < 12; i++) cyc(1, prod[i], 0, 0, 0);
        idle(1, 0);
        chk("ovr_ovf", 32'(ovf), 1);
        chk("ovr_head", 32'(acc_out), 130);
        idle(4, 1);
        chk_got("overrun", 2, 130, 242, 0);
        chk("ovr_sticky", 32'(ovf), 1);

        // Full FIFO with pop on the final beat.
        do_reset();
        for (int i = 0; i < 11; i++) cyc(1, prod[i], 0, 0, 0);
        cyc(1, prod[11], 0, 1, 0);
        chk("fullpop_ovf", 32'(ovf), 0);
        idle(4, 1);
        chk_got("fullpop", 3, 130, 242, 226);

        // frame_clr with a beat restarts the frame on that beat.
        cyc(1, 15, 0, 1, 0);
        cyc(1, 28, 0, 1, 0);
        cyc(1, 39, 1, 1, 0);
        cyc(1, 48, 0, 1, 0);
        cyc(1, 55, 0, 1, 0);
        cyc(1, 60, 0, 1, 0);
        idle(2, 1);
        chk_got("clr_beat", 1, 202, 0, 0);

        // frame_clr alone.
        cyc(1, 15, 0, 1, 0);
        cyc(1, 28, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        chk("clr_cnt", 32'(beat_cnt), 0);
        chk("clr_busy", 32'(busy), 0);

        // Reset mid-frame with one sum queued.
        for (int i = 0; i < 4; i++) cyc(1, prod[i], 0, 0, 0);
        for (int i = 4; i < 7; i++) cyc(1, prod[i], 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("rst_vld", 32'(acc_vld), 0);
        chk("rst_out", 32'(acc_out), 0);
        chk("rst_cnt", 32'(beat_cnt), 0);
        got.delete();
        for (int i = 0; i < 4; i++) cyc(1, prod[i], 0, 1, 0);
        idle(2, 1);
        chk_got("after_rst", 1, 130, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 3) != 0,
                int'($urandom_range(0, 511)),
                $urandom_range(0, 31) == 0,
                $urandom_range(0, 2) != 0,
                $urandom_range(0, 499) == 0);
        end
        // Saturating products exercise the widest sum.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 511, 0, 1, 0);
        chk("max_sum", 32'(acc_out), 2044);
        idle(2, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
